frame_scanout: RTL and testbench



---
 rtl/frame_scanout_pkg.sv | 18 +
 rtl/frame_scanout_fifo.sv | 56 +++++
 rtl/frame_scanout.sv | 189 ++++++++++++++++++
 tb/tb_frame_scanout.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_scanout_pkg.sv
// Shared types and defaults for the frame buffer scan-out reader.
package frame_scanout_pkg;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int RD_LATENCY_DEF = 2;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef logic [15:0] pixel_t;
    typedef logic [9:0]  coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/frame_scanout_fifo.sv
// Prefetch FIFO for scan-out: synchronous push/pop, flush, occupancy count.
// Read data is the current head and is valid whenever the count is non-zero.
module scanout_fifo
    import frame_scanout_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
)(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  pixel_t                     i_wdata,
    output pixel_t                     o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pixel_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop  && (r_count != '0);

    // Pointer and occupancy tracking; flush empties the queue outright.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage write; contents need no reset since the count gates reads.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/frame_scanout.sv
// Display-side frame buffer reader: raster-order prefetch into a small FIFO,
// one pixel per Pixel_Req, and front/back buffer swap at frame start.
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Frame_Start,
    input  logic        Pixel_Req,
    input  logic        Swap_Req,
    output logic        Swap_Ack,
    output logic        Front_Buf,
    output logic        FB_Re,
    output logic        FB_Buf,
    output logic [9:0]  FB_AddrX,
    output logic [9:0]  FB_AddrY,
    input  logic [15:0] FB_Data,
    output logic [15:0] Pixel_Out,
    output logic        Pixel_Valid,
    output logic        Underflow,
    output logic        Frame_Done
);

    localparam int     CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int     TW     = CW + 2;   // room for occupancy + in-flight sums
    localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

    scan_state_t          r_state;
    coord_t               r_x;            // next column to issue
    coord_t               r_y;            // next row to issue
    logic                 r_fb_re;
    coord_t               r_addr_x;
    coord_t               r_addr_y;
    logic                 r_front;
    logic                 r_fb_buf;
    logic                 r_swap_ack;
    logic                 r_frame_done;
    logic [RD_LATENCY-1:0] r_pipe;        // in-flight reads, bit L-1 returns now
    logic [TW-1:0]        r_drop;         // stale returns still to discard
    pixel_t               r_pix_out;
    logic                 r_pix_valid;
    logic                 r_underflow;

    logic [CW-1:0]        w_count;
    pixel_t               w_rdata;
    logic                 w_ret;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_last;
    logic                 w_done;
    logic [TW-1:0]        w_pipe_cnt;
    logic [TW-1:0]        w_pend;
    logic [TW-1:0]        w_total;
    logic [TW-1:0]        w_new_drop;
    coord_t               w_ix;
    coord_t               w_iy;

    scanout_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (Frame_Start),
        .i_wdata (FB_Data),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    // Issue/credit bookkeeping: a read may go out only if every outstanding
    // live read plus the FIFO contents still leaves room after this edge.
    always_comb begin
        w_pipe_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_pipe_cnt = w_pipe_cnt + TW'(r_pipe[i]);
        end
        w_ret      = r_pipe[RD_LATENCY-1];
        w_push     = w_ret && (r_drop == '0) && !Frame_Start;
        w_pop      = Pixel_Req && (r_state != ST_IDLE) && (w_count != '0);
        w_pend     = w_pipe_cnt + TW'(r_fb_re) - r_drop;
        w_total    = TW'(w_count) + w_pend - TW'(w_pop);
        w_new_drop = w_pipe_cnt + TW'(r_fb_re) - TW'(w_ret);
        w_ix       = Frame_Start ? '0 : r_x;
        w_iy       = Frame_Start ? '0 : r_y;
        w_issue    = Frame_Start ||
                     ((r_state == ST_FETCH) && (w_total < TW'(FIFO_DEPTH)));
        w_last     = (w_ix == X_LAST) && (w_iy == Y_LAST);
        w_done     = (r_state == ST_DRAIN) && !Frame_Start && w_pop &&
                     (w_count == CW'(1)) && (w_pend == '0);
    end

    // Frame sequencer: read issue, raster walk, swap commit and frame end.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_fb_re      <= 1'b0;
            r_addr_x     <= '0;
            r_addr_y     <= '0;
            r_front      <= 1'b0;
            r_fb_buf     <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_swap_ack   <= 1'b0;
            r_frame_done <= 1'b0;
            r_fb_re      <= w_issue;

            if (w_issue) begin
                r_addr_x <= w_ix;
                r_addr_y <= w_iy;
                if (w_ix == X_LAST) begin
                    r_x <= '0;
                    r_y <= w_iy + 1'b1;
                end else begin
                    r_x <= w_ix + 1'b1;
                    r_y <= w_iy;
                end
            end

            if (Frame_Start) begin
                // Reads still in the memory pipe belong to the old frame.
                r_drop <= w_new_drop;
                if (Swap_Req) begin
                    r_front    <= ~r_front;
                    r_fb_buf   <= ~r_front;
                    r_swap_ack <= 1'b1;
                end else begin
                    r_fb_buf   <= r_front;
                end
                r_state <= w_last ? ST_DRAIN : ST_FETCH;
            end else begin
                if (w_ret && (r_drop != '0)) r_drop <= r_drop - 1'b1;
                case (r_state)
                    ST_FETCH: if (w_issue && w_last) r_state <= ST_DRAIN;
                    ST_DRAIN: if (w_done) begin
                        r_state      <= ST_IDLE;
                        r_frame_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read-latency tracker: one bit per cycle of memory pipeline.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | RD_LATENCY'(r_fb_re);
        end
    end

    // Pixel response, one cycle after the request; empty FIFO latches Underflow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pix_out   <= '0;
            r_pix_valid <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pix_valid <= w_pop;
            r_pix_out   <= w_pop ? w_rdata : '0;
            if (Pixel_Req && !w_pop) r_underflow <= 1'b1;
        end
    end

    assign Swap_Ack    = r_swap_ack;
    assign Front_Buf   = r_front;
    assign FB_Re       = r_fb_re;
    assign FB_Buf      = r_fb_buf;
    assign FB_AddrX    = r_addr_x;
    assign FB_AddrY    = r_addr_y;
    assign Pixel_Out   = r_pix_out;
    assign Pixel_Valid = r_pix_valid;
    assign Underflow   = r_underflow;
    assign Frame_Done  = r_frame_done;

endmodule

// File: tb/tb_frame_scanout.sv
// Scoreboard bench for frame_scanout on a reduced 20x6 raster.
module tb_frame_scanout;

    localparam int H     = 20;
    localparam int V     = 6;
    localparam int LAT   = 2;
    localparam int DEPTH = 16;
    localparam int NPIX  = H * V;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Frame_Start = 1'b0;
    logic        Pixel_Req = 1'b0;
    logic        Swap_Req = 1'b0;
    logic        Swap_Ack, Front_Buf, FB_Re, FB_Buf;
    logic [9:0]  FB_AddrX, FB_AddrY;
    logic [15:0] FB_Data, Pixel_Out;
    logic        Pixel_Valid, Underflow, Frame_Done;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q [$];
    int          done_cnt = 0;
    int          re_cnt = 0;
    int          ack_cnt = 0;
    int          valid_cnt = 0;
    int          ex = 0;
    int          ey = 0;
    logic        exp_buf = 1'b0;
    logic        nxt_buf = 1'b0;
    logic [15:0] fb_p1, fb_p2;

    frame_scanout #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .RD_LATENCY (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Frame_Start (Frame_Start),
        .Pixel_Req   (Pixel_Req),
        .Swap_Req    (Swap_Req),
        .Swap_Ack    (Swap_Ack),
        .Front_Buf   (Front_Buf),
        .FB_Re       (FB_Re),
        .FB_Buf      (FB_Buf),
        .FB_AddrX    (FB_AddrX),
        .FB_AddrY    (FB_AddrY),
        .FB_Data     (FB_Data),
        .Pixel_Out   (Pixel_Out),
        .Pixel_Valid (Pixel_Valid),
        .Underflow   (Underflow),
        .Frame_Done  (Frame_Done)
    );

    always #10 Clk = ~Clk;

    function automatic logic [15:0] pix(int x, int y);
        logic [9:0] xx;
        logic [9:0] yy;
        xx = x[9:0];
        yy = y[9:0];
        return {yy[5:0], xx};
    endfunction

    // Frame buffer model: data = {Y[5:0], X}, two-cycle synchronous read.
    always @(posedge Clk) begin
        fb_p1 <= pix(int'(FB_AddrX), int'(FB_AddrY));
        fb_p2 <= fb_p1;
    end
    assign FB_Data = fb_p2;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected pixels on each valid response, checks read stream.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Pixel_Valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) chk("pixel_unexpected", 32'(exp_q.size()), 32'd1);
                else chk("pixel", {16'd0, Pixel_Out}, {16'd0, exp_q.pop_front()});
            end else begin
                chk("pix_invalid_zero", {16'd0, Pixel_Out}, 32'd0);
            end
            if (Frame_Done) begin
                done_cnt++;
                chk("done_on_last_pop", {30'd0, Pixel_Valid, exp_q.size() == 0}, 32'd3);
            end
            if (FB_Re) begin
                re_cnt++;
                chk("rd_addr", {12'd0, FB_AddrY, FB_AddrX}, 32'((ey << 10) | ex));
                chk("rd_buf", {31'd0, FB_Buf}, {31'd0, exp_buf});
                ex++;
                if (ex == H) begin
                    ex = 0;
                    ey++;
                end
            end
            if (Swap_Ack) ack_cnt++;
            if (Frame_Start) begin
                ex = 0;
                ey = 0;
                exp_buf = nxt_buf;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic start_frame(logic swap, logic buf_exp);
        Swap_Req    = swap;
        nxt_buf     = buf_exp;
        Frame_Start = 1'b1;
        done_cnt    = 0;
        re_cnt      = 0;
        valid_cnt   = 0;
        exp_q.delete();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                exp_q.push_back(pix(x, y));
        cyc(1);
        Frame_Start = 1'b0;
    endtask

    task automatic bursts(int n);
        int sent;
        sent = 0;
        while (sent < n) begin
            Pixel_Req = 1'b1;
            cyc(1);
            sent++;
            if (sent % H == 0) begin
                Pixel_Req = 1'b0;
                cyc(4);
            end
        end
        Pixel_Req = 1'b0;
    endtask

    task automatic wait_done(string tag, int max);
        int k;
        k = 0;
        while (done_cnt == 0 && k < max) begin
            cyc(1);
            k++;
        end
        cyc(3);
        chk({tag, "_frame_done_once"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_Front_Buf"},   {31'd0, Front_Buf},   32'd0);
        chk({tag, "_FB_Buf"},      {31'd0, FB_Buf},      32'd0);
        chk({tag, "_FB_Re"},       {31'd0, FB_Re},       32'd0);
        chk({tag, "_FB_AddrX"},    {22'd0, FB_AddrX},    32'd0);
        chk({tag, "_FB_AddrY"},    {22'd0, FB_AddrY},    32'd0);
        chk({tag, "_Pixel_Out"},   {16'd0, Pixel_Out},   32'd0);
        chk({tag, "_Pixel_Valid"}, {31'd0, Pixel_Valid}, 32'd0);
        chk({tag, "_Swap_Ack"},    {31'd0, Swap_Ack},    32'd0);
        chk({tag, "_Underflow"},   {31'd0, Underflow},   32'd0);
        chk({tag, "_Frame_Done"},  {31'd0, Frame_Done},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2 Reset_n = 1'b0;
        #3 chk_reset("reset");
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        cyc(2);

        // A: no requests -> exactly DEPTH reads at (0..15,0), then FB_Re low
        start_frame(1'b0, 1'b0);
        cyc(40);
        chk("A_read_count", 32'(re_cnt), 32'd16);
        chk("A_re_low", {31'd0, FB_Re}, 32'd0);
        chk("A_front", {31'd0, Front_Buf}, 32'd0);
        chk("A_no_ack", 32'(ack_cnt), 32'd0);

        // B: full frame with line bursts and blank gaps
        start_frame(1'b0, 1'b0);
        cyc(19);
        bursts(NPIX);
        wait_done("B", 200);
        chk("B_pixels", 32'(valid_cnt), 32'(NPIX));
        chk("B_reads", 32'(re_cnt), 32'(NPIX));
        chk("B_underflow", {31'd0, Underflow}, 32'd0);

        // C: swap committed at frame start; mid-frame request ignored
        ack_cnt = 0;
        Swap_Req = 1'b1;
        cyc(1);
        start_frame(1'b1, 1'b1);
        chk("C_ack_pulse", {31'd0, Swap_Ack}, 32'd1);
        chk("C_front_1", {31'd0, Front_Buf}, 32'd1);
        chk("C_fb_buf_1", {31'd0, FB_Buf}, 32'd1);
        Swap_Req = 1'b0;
        cyc(1);
        chk("C_ack_low", {31'd0, Swap_Ack}, 32'd0);
        cyc(18);
        bursts(60);
        Swap_Req = 1'b1;
        bursts(60);
        wait_done("C", 200);
        chk("C_front_held", {31'd0, Front_Buf}, 32'd1);
        chk("C_ack_count", 32'(ack_cnt), 32'd1);

        // D: swap back, then restart mid-frame with reads in flight
        start_frame(1'b1, 1'b0);
        chk("D_front_0", {31'd0, Front_Buf}, 32'd0);
        chk("D_ack_pulse", {31'd0, Swap_Ack}, 32'd1);
        Swap_Req = 1'b0;
        cyc(19);
        Pixel_Req = 1'b1;
        cyc(60);
        Pixel_Req = 1'b0;
        cyc(1);
        start_frame(1'b0, 1'b0);
        cyc(19);
        bursts(NPIX);
        wait_done("D", 200);
        chk("D_pixels", 32'(valid_cnt), 32'(NPIX));
        chk("D_underflow", {31'd0, Underflow}, 32'd0);
        chk("D_front", {31'd0, Front_Buf}, 32'd0);

        // E: asynchronous reset in the middle of FETCH
        start_frame(1'b1, 1'b1);
        Swap_Req = 1'b0;
        chk("E_front_1", {31'd0, Front_Buf}, 32'd1);
        cyc(5);
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1 chk_reset("E_async");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        cyc(3);

        // F: Pixel_Req held from Frame_Start+1 -> first response underflows
        start_frame(1'b0, 1'b0);
        Pixel_Req = 1'b1;
        cyc(1);
        chk("F_first_valid", {31'd0, Pixel_Valid}, 32'd0);
        chk("F_first_out", {16'd0, Pixel_Out}, 32'd0);
        chk("F_underflow_set", {31'd0, Underflow}, 32'd1);
        wait_done("F", 400);
        Pixel_Req = 1'b0;
        cyc(2);
        chk("F_pixels", 32'(valid_cnt), 32'(NPIX));
        chk("F_underflow_sticky", {31'd0, Underflow}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
